// File: rtl/jk_pkg.sv
// Shared types and JK table helpers for the excitation sequencer.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Excitation table inverse: returns {J, K}; don't-cares resolve to 0 so toggle is never issued.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        logic [1:0] jk;
        case ({cur, nxt})
            2'b01:   jk = 2'b10;
            2'b10:   jk = 2'b01;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with asynchronous active-high reset to 0.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= 1'b0;
        else     r_q <= jk_next(i_j, i_k, r_q);
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_excite_seq.sv
// Drives a JK flip-flop bank toward an accepted target, at most MAX_FLIPS bits per step,
// and checks each step against the JK characteristic equation.
module jk_excite_seq
    import jk_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_FLIPS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [W-1:0] tgt_data,
    output logic [W-1:0] j_out,
    output logic [W-1:0] k_out,
    output logic [W-1:0] q,
    output logic [5:0]   step_cnt,
    output logic         done,
    output logic         err
);

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_tgt;
    logic [5:0]     r_step_cnt;
    logic           r_err;
    logic [W-1:0]   w_q, w_diff, w_sel, w_j, w_k;
    int             w_cnt;
    logic           w_stepping;

    // Self-check history: the step just applied, compared against the bank one cycle later.
    logic           r_chk;
    logic [W-1:0]   r_pq, r_pj, r_pk, r_psel;
    logic           w_chk_bad;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cell
            jk_cell u_cell (
                .clk (clk),
                .rst (rst),
                .i_j (w_j[gi]),
                .i_k (w_k[gi]),
                .o_q (w_q[gi])
            );
        end
    endgenerate

    assign w_diff     = w_q ^ r_tgt;
    assign w_stepping = (r_state == STEP) && (w_diff != '0);

    always_comb begin
        w_sel = '0;
        w_cnt = 0;
        for (int i = 0; i < W; i++) begin
            if (w_diff[i] && (w_cnt < MAX_FLIPS)) begin
                w_sel[i] = 1'b1;
                w_cnt    = w_cnt + 1;
            end
        end
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        for (int i = 0; i < W; i++) begin
            if ((r_state == STEP) && w_sel[i])
                {w_j[i], w_k[i]} = jk_excite(w_q[i], r_tgt[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tgt_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                tgt_ready = 1'b1;
                if (tgt_valid) w_state_nxt = STEP;
            end
            STEP:    if (w_diff == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_chk_bad = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (w_q[i] != jk_next(r_pj[i], r_pk[i], r_pq[i])) w_chk_bad = 1'b1;
            if (r_psel[i] ? (w_q[i] != r_tgt[i]) : (w_q[i] != r_pq[i])) w_chk_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tgt      <= '0;
            r_step_cnt <= '0;
            r_err      <= 1'b0;
            r_chk      <= 1'b0;
            r_pq       <= '0;
            r_pj       <= '0;
            r_pk       <= '0;
            r_psel     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && tgt_valid) begin
                r_tgt      <= tgt_data;
                r_step_cnt <= '0;
            end else if (w_stepping && (r_step_cnt != 6'd63)) begin
                r_step_cnt <= r_step_cnt + 6'd1;
            end
            r_chk  <= w_stepping;
            r_pq   <= w_q;
            r_pj   <= w_j;
            r_pk   <= w_k;
            r_psel <= w_sel;
            if (r_chk && w_chk_bad) r_err <= 1'b1;
        end
    end

    assign j_out    = w_j;
    assign k_out    = w_k;
    assign q        = w_q;
    assign step_cnt = r_step_cnt;
    assign done     = (r_state == DONE);
    assign err      = r_err;

endmodule

// File: tb/tb_jk_excite_seq.sv
// Scoreboard bench: stimulus queues hand-computed step/done records, a negedge monitor pops and compares.
module tb_jk_excite_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] tgt_data;
    logic [7:0] j_out, k_out, q;
    logic [5:0] step_cnt;
    logic       done, err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit         is_done;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] q;
        logic [5:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    jk_excite_seq #(.W(8), .MAX_FLIPS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .j_out     (j_out),
        .k_out     (k_out),
        .q         (q),
        .step_cnt  (step_cnt),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_step(input logic [7:0] j, input logic [7:0] k, input logic [7:0] qb, input logic [5:0] c);
        exp_t e;
        e.is_done = 1'b0; e.j = j; e.k = k; e.q = qb; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic exp_done(input logic [7:0] qf, input logic [5:0] c);
        exp_t e;
        e.is_done = 1'b1; e.j = 8'h00; e.k = 8'h00; e.q = qf; e.cnt = c;
        sb.push_back(e);
    endtask

    // Offer a target until accepted; optionally wait for done and check the latency in cycles.
    task automatic send(input logic [7:0] t, input int lat, input bit wt);
        int n;
        tgt_valid = 1'b1;
        tgt_data  = t;
        n = 0;
        while (!tgt_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tgt_ready) begin
            chk("accept_timeout", 32'(n), 32'(0));
            tgt_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        if (wt) begin
            n = 0;
            while (!done && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("done_latency", 32'(n), 32'(lat));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (done || (j_out | k_out) != 8'h00)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got done=%0b j=%h k=%h q=%h expected nothing", done, j_out, k_out, q);
            end else begin
                m_e = sb.pop_front();
                chk("event_kind", 32'(done), 32'(m_e.is_done));
                if (m_e.is_done) begin
                    chk("done_q", 32'(q), 32'(m_e.q));
                    chk("done_step_cnt", 32'(step_cnt), 32'(m_e.cnt));
                    chk("done_err", 32'(err), 32'(0));
                end else begin
                    chk("step_j", 32'(j_out), 32'(m_e.j));
                    chk("step_k", 32'(k_out), 32'(m_e.k));
                    chk("step_q", 32'(q), 32'(m_e.q));
                    chk("step_cnt", 32'(step_cnt), 32'(m_e.cnt));
                    chk("step_ready", 32'(tgt_ready), 32'(0));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = 8'h00;
        #1;
        chk("rst_q", 32'(q), 32'(8'h00));
        chk("rst_ready", 32'(tgt_ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_jk", 32'({j_out, k_out}), 32'(16'h0000));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single step 00 -> 03
        exp_step(8'h03, 8'h00, 8'h00, 6'd0);
        exp_done(8'h03, 6'd1);
        send(8'h03, 2, 1'b1);

        // multi step 03 -> F0
        exp_step(8'h00, 8'h03, 8'h03, 6'd0);
        exp_step(8'h30, 8'h00, 8'h00, 6'd1);
        exp_step(8'hC0, 8'h00, 8'h30, 6'd2);
        exp_done(8'hF0, 6'd3);
        send(8'hF0, 4, 1'b1);

        // no-op target
        exp_done(8'hF0, 6'd0);
        send(8'hF0, 1, 1'b1);

        // busy ignore: 0x0F held while F0 -> 00 is stepping
        exp_step(8'h00, 8'h30, 8'hF0, 6'd0);
        exp_step(8'h00, 8'hC0, 8'hC0, 6'd1);
        exp_done(8'h00, 6'd2);
        send(8'h00, 0, 1'b0);
        tgt_valid = 1'b1;
        tgt_data  = 8'h0F;
        chk("busy_ready_s1", 32'(tgt_ready), 32'(0));
        @(posedge clk); #1;
        chk("busy_ready_s2", 32'(tgt_ready), 32'(0));
        exp_step(8'h03, 8'h00, 8'h00, 6'd0);
        exp_step(8'h0C, 8'h00, 8'h03, 6'd1);
        exp_done(8'h0F, 6'd2);
        send(8'h0F, 3, 1'b1);
        chk("busy_final_q", 32'(q), 32'(8'h0F));

        // back to 03, then reset during step 2 of 03 -> F0
        exp_step(8'h00, 8'h0C, 8'h0F, 6'd0);
        exp_done(8'h03, 6'd1);
        send(8'h03, 2, 1'b1);

        exp_step(8'h00, 8'h03, 8'h03, 6'd0);
        send(8'hF0, 0, 1'b0);
        @(posedge clk); #2;
        chk("mid_step2_j", 32'(j_out), 32'(8'h30));
        rst = 1'b1;
        #1;
        chk("midrst_q", 32'(q), 32'(8'h00));
        chk("midrst_ready", 32'(tgt_ready), 32'(1));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_jk", 32'({j_out, k_out}), 32'(16'h0000));
        chk("midrst_cnt", 32'(step_cnt), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        exp_step(8'h01, 8'h00, 8'h00, 6'd0);
        exp_done(8'h01, 6'd1);
        send(8'h01, 2, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'(0));
        chk("final_err", 32'(err), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_excite_seq.md
# jk_excite_seq

Sequential JK excitation driver: the inverse of the JK next-state logic used by the ATPG test circuits. It accepts a target W-bit state over a valid/ready handshake and derives per-bit J/K excitation from the JK excitation table. It drives an internal bank of JK flip-flops toward the target, changing at most MAX_FLIPS bits per cycle. It serves as the stimulus side for the gate-level JK benches: it produces legal J/K sequences, and it self-checks the bank against the JK characteristic equation.

## Interface
- W, default 8: state width, 1..32.
- MAX_FLIPS, default 2: maximum bits changed per step, 1..W.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tgt_valid  input  1  target offered.
- tgt_ready  output  1  high only in IDLE.
- tgt_data  input  W  target state.
- j_out  output  W  J excitation applied this cycle.
- k_out  output  W  K excitation applied this cycle.
- q  output  W  current flip-flop bank state.
- step_cnt  output  6  number of steps taken for the last or current target.
- done  output  1  one-cycle pulse when q equals the target.
- err  output  1  sticky self-check failure flag.

## Operation
- States are IDLE, STEP and DONE.
- Reset values: state IDLE, q=0, target register 0, step_cnt=0, done=0, err=0. j_out and k_out are 0 outside STEP.
- IDLE:
  - tgt_ready=1.
  - A target is accepted when tgt_valid and tgt_ready are both high at a clock edge.
  - On acceptance, tgt_data is latched, step_cnt clears to 0, and the state moves to STEP.
- STEP:
  - diff = q XOR target.
  - If diff=0, j_out=k_out=0 and the state moves to DONE. No step is counted.
  - Otherwise, select the lowest-index set bits of diff, up to MAX_FLIPS of them.
  - Excitation for a selected bit: 0→1 gives J=1, K=0; 1→0 gives J=0, K=1.
  - Excitation for an unselected bit is J=K=0 (hold). Table don't-cares are always resolved to 0, so J=K=1 (toggle) is never issued.
  - At the edge, q updates per bit as q' = (J & ~q) | (~K & q), and step_cnt increments (saturating at 63).
- Self-check: after each step, every selected bit must equal the target and every unselected bit must be unchanged. Any mismatch sets err, which stays set until rst.
- DONE: done=1 for exactly one cycle, then the state returns to IDLE. q holds.
- tgt_valid is ignored outside IDLE. tgt_data is sampled only on acceptance.

## Timing
- Handshake rule: a target is accepted on the edge where tgt_valid and tgt_ready are both high.
- Latency from acceptance edge to the done pulse is S+1 cycles, where S = ceil(popcount(q XOR target) / MAX_FLIPS).
  - Target equal to the current q: S=0, done in the cycle after acceptance.
- j_out and k_out are combinational from state, q and target. They are valid throughout STEP cycles and are consumed at the following edge.
- tgt_ready is high in the same cycle the state returns to IDLE, so back-to-back targets cost one IDLE cycle.
- Reset mid-operation: q, state and all outputs return to their reset values immediately, without waiting for a clock. An in-flight target is discarded.
- Simultaneous rst and tgt_valid: rst wins and nothing is accepted.

## Structure
- Package jk_pkg contains:
  - the state enum (IDLE, STEP, DONE);
  - the function jk_excite(cur, nxt) returning {J, K} with don't-cares resolved to 0;
  - the function jk_next(j, k, q).
- The sub-module jk_cell is one JK flip-flop with asynchronous active-high reset to 0. It is instantiated W times; q is the concatenation of the cells.
- Lowest-set-bit selection is a priority mask loop inside jk_excite_seq.

## Test plan
Parameters for all scenarios: W=8, MAX_FLIPS=2.
- **Reset:** assert rst → q=0x00, tgt_ready=1, done=0, err=0, j_out=k_out=0x00.
- **Single step:** from q=0x00, send target 0x03 → one STEP with j_out=0x03, k_out=0x00; q=0x03; done one cycle later; step_cnt=1.
- **Multi-step:** from q=0x03, send target 0xF0 → three steps:
  - step 1: j=0x00, k=0x03, giving q=0x00;
  - step 2: j=0x30, k=0x00, giving q=0x30;
  - step 3: j=0xC0, k=0x00, giving q=0xF0.
  - Then done, with step_cnt=3 and err=0.
- **No-op target:** send target equal to q (0xF0) → no excitation issued, done in the cycle after acceptance, step_cnt=0.
- **Busy ignore:** hold tgt_valid=1 with target 0x0F while a prior target is in STEP → tgt_ready=0 and the new target is not accepted. It is accepted on the IDLE cycle after done and completes with q=0x0F.
- **Reset mid-step:** assert rst during step 2 of the 0x03→0xF0 run → q=0x00 and state IDLE immediately, with no done pulse. After rst deasserts, target 0x01 completes normally.
